// File: rtl/eae_pkg.sv
// rtl/eae_pkg.sv - shared op codes and FSM state encoding for the EAE shift unit
package eae_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_SHL = 3'd1,
        OP_ASR = 3'd2,
        OP_LSR = 3'd3,
        OP_NMI = 3'd4
    } eae_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } eae_state_e;

endpackage

// File: rtl/eae_shift_step.sv
// rtl/eae_shift_step.sv - one-bit shift of {AC,MQ} plus normalize-stop detection on the result
module eae_shift_step #(
    parameter int W = 12
) (
    input  logic [2:0]   op,
    input  logic         link,
    input  logic [W-1:0] ac,
    input  logic [W-1:0] mq,
    output logic         link_next,
    output logic [W-1:0] ac_next,
    output logic [W-1:0] mq_next,
    output logic         nmi_stop
);
    import eae_pkg::*;

    localparam logic [2*W-1:0] NMI_TOP = {2'b11, {(2*W-2){1'b0}}};

    always_comb begin
        link_next = link;
        ac_next   = ac;
        mq_next   = mq;
        case (op)
            OP_SHL: begin
                {ac_next, mq_next} = {ac, mq} << 1;
                link_next          = ac[W-1];
            end
            OP_NMI: begin
                {ac_next, mq_next} = {ac, mq} << 1;
            end
            OP_ASR: begin
                ac_next   = {ac[W-1], ac[W-1:1]};
                mq_next   = {ac[0], mq[W-1:1]};
                link_next = ac[W-1];
            end
            OP_LSR: begin
                ac_next   = {1'b0, ac[W-1:1]};
                mq_next   = {ac[0], mq[W-1:1]};
                link_next = 1'b0;
            end
            default: ;
        endcase
    end

    // Evaluated on the shifted value so the FSM can leave SHIFT in the same cycle
    assign nmi_stop = (ac_next[W-1] != ac_next[W-2])
                    || ({ac_next, mq_next} == NMI_TOP)
                    || ({ac_next, mq_next} == '0);

endmodule

// File: rtl/eae_shift_unit.sv
// rtl/eae_shift_unit.sv - multi-cycle AC/MQ shift and normalize unit
module eae_shift_unit #(
    parameter int W      = 12,
    parameter int SCW    = 5,
    parameter int MODE_B = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2:0]     op,
    input  logic [SCW-1:0] count,
    input  logic [W-1:0]   ac_in,
    input  logic [W-1:0]   mq_in,
    input  logic           link_in,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   ac_out,
    output logic [W-1:0]   mq_out,
    output logic           link_out,
    output logic [SCW-1:0] sc_out
);
    import eae_pkg::*;

    localparam int CAPW = $clog2(2 * W);
    localparam int RW   = (SCW + 1 > CAPW) ? SCW + 1 : CAPW;
    localparam logic [RW-1:0]  NMI_CAP = RW'(2 * W - 1);
    localparam logic [2*W-1:0] NMI_TOP = {2'b11, {(2*W-2){1'b0}}};

    eae_state_e     state, state_nx;
    logic [2:0]     op_q;
    logic [RW-1:0]  rem;
    logic [SCW:0]   n_shift;
    logic           is_shift_op;
    logic           init_stop;
    logic           go_shift;
    logic           last_shift;
    logic           step_link;
    logic [W-1:0]   step_ac;
    logic [W-1:0]   step_mq;
    logic           step_stop;

    // Computed one bit wider than count so an all-ones count in mode A does not wrap
    assign n_shift = (MODE_B != 0) ? {1'b0, count} : {1'b0, count} + 1'b1;

    assign is_shift_op = (op == OP_SHL) || (op == OP_ASR) || (op == OP_LSR);
    assign init_stop   = (ac_in[W-1] != ac_in[W-2])
                       || ({ac_in, mq_in} == NMI_TOP)
                       || ({ac_in, mq_in} == '0);
    assign go_shift    = (is_shift_op && (n_shift != '0)) || ((op == OP_NMI) && !init_stop);
    assign last_shift  = (rem == RW'(1)) || ((op_q == OP_NMI) && step_stop);

    eae_shift_step #(.W(W)) u_step (
        .op        (op_q),
        .link      (link_out),
        .ac        (ac_out),
        .mq        (mq_out),
        .link_next (step_link),
        .ac_next   (step_ac),
        .mq_next   (step_mq),
        .nmi_stop  (step_stop)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = go_shift ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (last_shift) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ac_out   <= '0;
            mq_out   <= '0;
            link_out <= 1'b0;
            sc_out   <= '0;
            op_q     <= 3'd0;
            rem      <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    ac_out   <= ac_in;
                    mq_out   <= mq_in;
                    link_out <= link_in;
                    op_q     <= op;
                    rem      <= (op == OP_NMI) ? NMI_CAP : RW'(n_shift);
                    sc_out   <= (is_shift_op && (n_shift != '0)) ? SCW'(n_shift - 1'b1) : '0;
                end
                ST_SHIFT: begin
                    ac_out   <= step_ac;
                    mq_out   <= step_mq;
                    link_out <= step_link;
                    rem      <= rem - 1'b1;
                    if (op_q == OP_NMI)     sc_out <= sc_out + 1'b1;
                    else if (sc_out != '0)  sc_out <= sc_out - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eae_shift_unit.sv
// tb/tb_eae_shift_unit.sv - self-checking bench for eae_shift_unit in modes A and B
module tb_eae_shift_unit;

    logic        clk, reset, start_a, start_b, link_in, sel_b;
    logic [2:0]  op;
    logic [4:0]  count;
    logic [11:0] ac_in, mq_in;

    logic        busy_a, done_a, link_a, busy_b, done_b, link_b;
    logic [11:0] ac_a, mq_a, ac_b, mq_b;
    logic [4:0]  sc_a, sc_b;

    logic        s_busy, s_done, s_link;
    logic [11:0] s_ac, s_mq;
    logic [4:0]  s_sc;

    int errors = 0;
    int checks = 0;

    eae_shift_unit #(.W(12), .SCW(5), .MODE_B(0)) dut (
        .clk(clk), .reset(reset), .start(start_a), .op(op), .count(count),
        .ac_in(ac_in), .mq_in(mq_in), .link_in(link_in),
        .busy(busy_a), .done(done_a), .ac_out(ac_a), .mq_out(mq_a),
        .link_out(link_a), .sc_out(sc_a)
    );

    eae_shift_unit #(.W(12), .SCW(5), .MODE_B(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .op(op), .count(count),
        .ac_in(ac_in), .mq_in(mq_in), .link_in(link_in),
        .busy(busy_b), .done(done_b), .ac_out(ac_b), .mq_out(mq_b),
        .link_out(link_b), .sc_out(sc_b)
    );

    assign s_busy = sel_b ? busy_b : busy_a;
    assign s_done = sel_b ? done_b : done_a;
    assign s_link = sel_b ? link_b : link_a;
    assign s_ac   = sel_b ? ac_b   : ac_a;
    assign s_mq   = sel_b ? mq_b   : mq_a;
    assign s_sc   = sel_b ? sc_b   : sc_a;

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  cnt;
        logic [11:0] ac;
        logic [11:0] mq;
        logic        l;
        int          cyc;
        logic [11:0] eac;
        logic [11:0] emq;
        logic        el;
        logic [4:0]  esc;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Whole-word reference: shift ops as one N-place shift, NMI as a normalize loop
    function automatic void model(input bit mb, input logic [2:0] o, input logic [4:0] c,
                                  input logic [11:0] a, input logic [11:0] m, input logic l,
                                  output int cyc, output logic [11:0] ea, output logic [11:0] em,
                                  output logic el, output logic [4:0] esc);
        longint x, y, s;
        int n, k;
        x = longint'({a, m});
        ea = a; em = m; el = l; esc = 5'd0; cyc = 1;
        if (o == 3'd1 || o == 3'd2 || o == 3'd3) begin
            n = mb ? int'(c) : int'(c) + 1;
            cyc = n + 1;
            if (n > 0) begin
                if (o == 3'd1) begin
                    y = x << n;
                    el = y[24];
                end else if (o == 3'd2) begin
                    s = a[11] ? (x | 64'hFFFF_FFFF_FF00_0000) : x;
                    y = s >>> n;
                    el = a[11];
                end else begin
                    y = x >> n;
                    el = 1'b0;
                end
                {ea, em} = y[23:0];
            end
        end else if (o == 3'd4) begin
            k = 0;
            while (k < 23 && !((x[23] != x[22]) || (x == 64'hC00000) || (x == 0))) begin
                x = (x << 1) & 64'hFFFFFF;
                k++;
            end
            {ea, em} = x[23:0];
            esc = 5'(k);
            cyc = k + 1;
        end
    endfunction

    task automatic run(input bit use_b, input logic [2:0] o, input logic [4:0] c,
                       input logic [11:0] a, input logic [11:0] m, input logic l,
                       input int glitch, output int cyc);
        @(negedge clk);
        sel_b = use_b;
        op = o; count = c; ac_in = a; mq_in = m; link_in = l;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        cyc = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0;
            if (s_done) begin
                cyc = k;
                break;
            end
            if (k == glitch) begin
                op = 3'($urandom_range(0, 7)); count = 5'($urandom);
                ac_in = 12'($urandom); mq_in = 12'($urandom); link_in = ~l;
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end
        end
    endtask

    task automatic check_vec(input string nm, input int cyc, input int ecyc,
                             input logic [11:0] ea, input logic [11:0] em,
                             input logic el, input logic [4:0] es);
        chk({nm, " cycle"}, cyc, ecyc);
        chk({nm, " ac"}, s_ac, ea);
        chk({nm, " mq"}, s_mq, em);
        chk({nm, " link"}, s_link, el);
        chk({nm, " sc"}, s_sc, es);
        @(posedge clk); #1;
        chk({nm, " idle"}, {s_busy, s_done}, 2'b00);
        chk({nm, " hold"}, {s_ac, s_mq, s_link}, {ea, em, el});
    endtask

    initial begin
        int cyc, ecyc;
        logic [11:0] ea, em;
        logic el, ub, lr;
        logic [4:0] es, cr;
        logic [2:0] orand;
        logic [11:0] ar, mr;

        clk = 0; reset = 1; start_a = 0; start_b = 0; sel_b = 0;
        op = 0; count = 0; ac_in = 0; mq_in = 0; link_in = 0;

        tbl[0] = '{3'd1, 5'd2,  12'o4001, 12'o0003, 1'b0, 4,  12'o0010, 12'o0030, 1'b0, 5'd0};
        tbl[1] = '{3'd2, 5'd0,  12'o7770, 12'o0001, 1'b0, 2,  12'o7774, 12'o0000, 1'b1, 5'd0};
        tbl[2] = '{3'd3, 5'd4,  12'o4000, 12'o0000, 1'b0, 6,  12'o0100, 12'o0000, 1'b0, 5'd0};
        tbl[3] = '{3'd4, 5'd0,  12'o0001, 12'o0000, 1'b1, 11, 12'o2000, 12'o0000, 1'b1, 5'd10};
        tbl[4] = '{3'd4, 5'd7,  12'o0000, 12'o0000, 1'b0, 1,  12'o0000, 12'o0000, 1'b0, 5'd0};
        tbl[5] = '{3'd4, 5'd0,  12'o6000, 12'o0000, 1'b0, 1,  12'o6000, 12'o0000, 1'b0, 5'd0};
        tbl[6] = '{3'd0, 5'd9,  12'o1234, 12'o4321, 1'b1, 1,  12'o1234, 12'o4321, 1'b1, 5'd0};
        tbl[7] = '{3'd7, 5'd3,  12'o7070, 12'o0707, 1'b0, 1,  12'o7070, 12'o0707, 1'b0, 5'd0};
        tbl[8] = '{3'd1, 5'd31, 12'o7777, 12'o7777, 1'b0, 33, 12'o0000, 12'o0000, 1'b0, 5'd0};
        tbl[9] = '{3'd2, 5'd31, 12'o4000, 12'o0000, 1'b0, 33, 12'o7777, 12'o7777, 1'b1, 5'd0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy_a, 1'b0);
        chk("reset done", done_a, 1'b0);
        chk("reset ac", ac_a, 12'd0);
        chk("reset mq", mq_a, 12'd0);
        chk("reset link", link_a, 1'b0);
        chk("reset sc", sc_a, 5'd0);
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < 10; i++) begin
            run(1'b0, tbl[i].op, tbl[i].cnt, tbl[i].ac, tbl[i].mq, tbl[i].l, -1, cyc);
            check_vec($sformatf("vec%0d", i), cyc, tbl[i].cyc, tbl[i].eac, tbl[i].emq, tbl[i].el, tbl[i].esc);
        end

        run(1'b1, 3'd3, 5'd0, 12'o4000, 12'o0000, 1'b0, -1, cyc);
        check_vec("modeb lsr0", cyc, 1, 12'o4000, 12'o0000, 1'b0, 5'd0);

        for (int i = 0; i < 40; i++) begin
            ub = 1'($urandom); orand = 3'($urandom_range(0, 7)); cr = 5'($urandom);
            ar = 12'($urandom); mr = 12'($urandom); lr = 1'($urandom);
            if (i % 5 == 0) ar = ar >> $urandom_range(1, 11);
            model(ub, orand, cr, ar, mr, lr, ecyc, ea, em, el, es);
            run(ub, orand, cr, ar, mr, lr, -1, cyc);
            check_vec($sformatf("rand%0d b%0d op%0d", i, ub, orand), cyc, ecyc, ea, em, el, es);
        end

        model(1'b0, 3'd1, 5'd5, 12'o1234, 12'o5670, 1'b1, ecyc, ea, em, el, es);
        run(1'b0, 3'd1, 5'd5, 12'o1234, 12'o5670, 1'b1, 2, cyc);
        check_vec("busy start shl", cyc, ecyc, ea, em, el, es);
        model(1'b1, 3'd2, 5'd6, 12'o4321, 12'o0077, 1'b0, ecyc, ea, em, el, es);
        run(1'b1, 3'd2, 5'd6, 12'o4321, 12'o0077, 1'b0, 3, cyc);
        check_vec("busy start asr", cyc, ecyc, ea, em, el, es);

        @(negedge clk);
        sel_b = 0; op = 3'd1; count = 5'd10; ac_in = 12'o1234; mq_in = 12'o4321; link_in = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid busy", busy_a, 1'b1);
        #1;
        reset = 1;
        #1;
        chk("mid reset busy/done", {busy_a, done_a}, 2'b00);
        chk("mid reset ac", ac_a, 12'd0);
        chk("mid reset mq", mq_a, 12'd0);
        chk("mid reset link/sc", {link_a, sc_a}, 6'd0);
        @(negedge clk);
        reset = 0;

        run(1'b0, tbl[0].op, tbl[0].cnt, tbl[0].ac, tbl[0].mq, tbl[0].l, -1, cyc);
        check_vec("post reset", cyc, tbl[0].cyc, tbl[0].eac, tbl[0].emq, tbl[0].el, tbl[0].esc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
